pipe_mem_ctrl: RTL and testbench
================================

Name: pipe_mem_ctrl

Overview:
- Pipeline sequencer for the five-stage core: merges stage stall requests into the 6-bit stall vector that drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Arbitrates the single external memory bus between instruction fetch (IF) and the data-access stage (MEM).
- Holds completed read data in per-requester buffers until the owning stage advances, so a stall from another stage never forces a refetch.

Parameters:
- TIMEOUT, 255: maximum bus cycles to wait for bus_ack before aborting a transaction.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stallreq_from_id  in  1  load-use hazard stall request
- stallreq_from_ex  in  1  multi-cycle EX operation stall request
- if_req  in  1  fetch request
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched instruction (buffered)
- mem_req  in  1  data access request
- mem_we  in  1  1 = store
- mem_sel  in  4  byte enables
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data (buffered)
- bus_req  out  1  bus cycle active
- bus_we  out  1  bus write
- bus_sel  out  4  bus byte enables
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data
- bus_ack  in  1  bus transfer complete
- stall  out  6  [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = stop
- bus_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset values: all registered outputs 0, including bus_req, bus_we, bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata and bus_err. State is IDLE; if_buf_valid, mem_buf_valid and the counter are 0. While rst=1, stall=0.
- Reset mid-transaction: bus_req drops on the first clock edge with rst=1 and the transaction is abandoned.
- Wait terms:
  - mem_wait = mem_req & !mem_buf_valid
  - if_wait = if_req & !if_buf_valid
- Stall is combinational, in priority order:
  - mem_wait -> 011111
  - else stallreq_from_ex -> 001111
  - else stallreq_from_id -> 000111
  - else if_wait -> 000111
  - else 000000
- FSM states: IDLE, IF_BUSY, MEM_BUSY.
- IDLE grant: if mem_wait, latch mem_we/sel/addr/wdata onto the bus registers and go to MEM_BUSY. Else if if_wait, latch if_addr with we=0 and sel=1111 and go to IF_BUSY. MEM always wins a simultaneous request.
- Grant timing: bus_req rises the cycle after the grant decision. The timeout counter clears on entry to a BUSY state.
- BUSY states: bus_req and the bus fields are held stable and the counter increments each cycle.
  - On bus_ack: if the read's owner still holds its req, capture bus_rdata into if_rdata or mem_rdata and set the matching buf_valid. Stores set mem_buf_valid but leave mem_rdata unchanged. Then bus_req drops next cycle and the FSM returns to IDLE.
  - If the owner's req is low at ack (flushed), the data is discarded and buf_valid is not set.
  - Back-to-back transactions have a minimum one-cycle gap with bus_req low.
  - bus_ack in IDLE is ignored.
- Timeout: when the counter reaches TIMEOUT with no ack, drop bus_req and pulse bus_err for one cycle. Set the owner's buf_valid with rdata=0, then return to IDLE.
- Buffer release:
  - if_buf_valid clears on any cycle with stall[1]=0.
  - mem_buf_valid clears on any cycle with stall[4]=0, which is always the cycle after it is set.
  - If a new ack and a release coincide, the set wins.
- While if_buf_valid=1, a MEM request may use the bus and if_rdata is held unchanged.

Test Plan:
- Fetch: if_req=1, if_addr=0x100, ack 2 cycles after bus_req with bus_rdata=0x24010005 -> bus_addr=0x100, bus_sel=1111, stall=000111 while waiting, if_rdata=0x24010005, stall=000000 the cycle after ack.
- Contention: if_req and mem_req (load, addr 0x200) both rise in the same cycle -> MEM granted first, stall=011111 until mem ack; IF transaction starts one idle cycle later.
- Buffered hold: IF ack while stallreq_from_ex=1 -> stall=001111, if_rdata held, no second bus cycle. When ex clears, stall=000000 and if_buf_valid clears.
- Store: mem_we=1, sel=0011, addr=0x300, wdata=0xDEADBEEF -> bus fields match; after ack, mem_rdata unchanged and stall clears.
- Timeout with TIMEOUT=4 and no ack -> bus_req high for 4 cycles then low, bus_err pulses once, mem_rdata=0, stall returns to 000000.
- Reset during MEM_BUSY -> bus_req=0 and stall=0 from the reset edge; after release, a new if_req is granted normally.

Source files
------------

// File: rtl/pipe_mem_ctrl.sv
// Five-stage pipeline sequencer: merges stage stall requests into the stall
// vector and arbitrates the single memory bus between IF and MEM with read buffers.
module pipe_mem_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [5:0]  stall,
  output logic        bus_err
);

  // Bus handshake: bus_req rises with stable we/sel/addr/wdata and holds them
  // until the cycle bus_ack is sampled high (or the timeout expires); bus_req
  // then drops for at least one cycle. bus_ack outside a busy state is ignored.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             if_buf_valid;
  logic             mem_buf_valid;
  logic [CNT_W-1:0] cnt;
  logic             mem_wait;
  logic             if_wait;

  assign mem_wait = mem_req & ~mem_buf_valid;
  assign if_wait  = if_req & ~if_buf_valid;

  always_comb begin
    stall = 6'b000000;
    if (rst)                                stall = 6'b000000;
    else if (mem_wait)                      stall = 6'b011111;
    else if (stallreq_from_ex)              stall = 6'b001111;
    else if (stallreq_from_id || if_wait)   stall = 6'b000111;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      if_buf_valid  <= 1'b0;
      mem_buf_valid <= 1'b0;
      cnt           <= '0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_sel       <= 4'b0000;
      bus_addr      <= 32'd0;
      bus_wdata     <= 32'd0;
      if_rdata      <= 32'd0;
      mem_rdata     <= 32'd0;
      bus_err       <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      // Buffers release when their stage advances; a same-cycle set below wins.
      if (!stall[1]) if_buf_valid  <= 1'b0;
      if (!stall[4]) mem_buf_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (mem_wait) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            cnt       <= '0;
            state     <= MEM_BUSY;
          end else if (if_wait) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= 4'b1111;
            bus_addr  <= if_addr;
            bus_wdata <= 32'd0;
            cnt       <= '0;
            state     <= IF_BUSY;
          end
        end

        IF_BUSY, MEM_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= IDLE;
            // A requester that dropped its req was flushed; its data is discarded.
            if (state == IF_BUSY) begin
              if (if_req) begin
                if_rdata     <= bus_rdata;
                if_buf_valid <= 1'b1;
              end
            end else if (mem_req) begin
              if (!bus_we) mem_rdata <= bus_rdata;
              mem_buf_valid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
            if (state == IF_BUSY) begin
              if_rdata     <= 32'd0;
              if_buf_valid <= 1'b1;
            end else begin
              mem_rdata     <= 32'd0;
              mem_buf_valid <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Directed bench for pipe_mem_ctrl: bus transactions and read data go through
// an expected queue checked by a monitor; stall vectors are checked per cycle.
module tb_pipe_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [5:0]  stall;
  logic        bus_err;

  typedef struct packed {
    logic        owner_mem;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        timeout;
    logic [3:0]  dur;
  } item_t;

  localparam int ITEM_W = $bits(item_t);

  logic [ITEM_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic resp_en;

  pipe_mem_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall(stall), .bus_err(bus_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_stall(input string name, input int n, input logic [5:0] exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, {26'd0, stall}, {26'd0, exp});
    end
  endtask

  task automatic push_item(input logic is_mem, input logic we, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic tmo, input logic [3:0] dur);
    item_t it;
    it.owner_mem = is_mem;
    it.we        = we;
    it.sel       = sel;
    it.addr      = addr;
    it.wdata     = wdata;
    it.rdata     = rdata;
    it.timeout   = tmo;
    it.dur       = dur;
    exp_q.push_back(it);
  endtask

  function automatic logic [31:0] resp_data(input logic [31:0] a);
    if (a == 32'h100)      return 32'h24010005;
    else if (a == 32'h200) return 32'h8C220010;
    else                   return a ^ 32'hA5A5A5A5;
  endfunction

  // ---------------- bus responder: ack two cycles after bus_req rises ----------------
  initial begin : responder
    int wait_cnt;
    wait_cnt  = 0;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      if (bus_req === 1'b1 && resp_en) begin
        if (wait_cnt == 2) begin
          bus_ack   = 1'b1;
          bus_rdata = resp_data(bus_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    item_t cur;
    logic  active;
    logic  prev_req;
    int    high_cnt;
    cur      = '0;
    active   = 1'b0;
    prev_req = 1'b0;
    high_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (bus_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_bus_cycle: got addr 0x%08h, no transaction expected", bus_addr);
            active = 1'b0;
          end else begin
            cur      = exp_q.pop_front();
            active   = 1'b1;
            high_cnt = 1;
            chk("bus_ctrl", {27'd0, bus_we, bus_sel}, {27'd0, cur.we, cur.sel});
            chk("bus_addr", bus_addr, cur.addr);
            chk("bus_wdata", bus_wdata, cur.wdata);
          end
        end else if (bus_req && active) begin
          high_cnt++;
          chk("bus_ctrl_hold", {27'd0, bus_we, bus_sel}, {27'd0, cur.we, cur.sel});
          chk("bus_addr_hold", bus_addr, cur.addr);
        end
        if (!bus_req && prev_req && active) begin
          chk("bus_req_cycles", high_cnt, {28'd0, cur.dur});
          chk("bus_err_at_end", {31'd0, bus_err}, {31'd0, cur.timeout});
          if (cur.owner_mem) chk("mem_rdata", mem_rdata, cur.rdata);
          else               chk("if_rdata", if_rdata, cur.rdata);
          active = 1'b0;
        end else begin
          chk("bus_err_quiet", {31'd0, bus_err}, 32'd0);
        end
      end
      prev_req = bus_req;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    rst = 1'b1;
    stallreq_from_id = 1'b0;
    stallreq_from_ex = 1'b0;
    if_req = 1'b0;  if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'd0; mem_wdata = 32'd0;
    resp_en = 1'b1;

    // Reset state, with requests present that must not stall during reset.
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b1; mem_req = 1'b1; mem_addr = 32'h700;
    @(negedge clk);
    chk("rst_stall", {26'd0, stall}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_ctrl", {27'd0, bus_we, bus_sel}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    tick(); if_req = 1'b0; mem_req = 1'b0;
    tick(); rst = 1'b0;
    expect_stall("idle", 1, 6'b000000);

    // Stage stall priority without bus traffic.
    tick(); stallreq_from_id = 1'b1;
    expect_stall("id_stall", 1, 6'b000111);
    tick(); stallreq_from_ex = 1'b1;
    expect_stall("ex_over_id", 1, 6'b001111);
    tick(); stallreq_from_id = 1'b0; stallreq_from_ex = 1'b0;
    expect_stall("no_stall", 1, 6'b000000);

    // Fetch from 0x100.
    tick(); if_req = 1'b1; if_addr = 32'h100;
    push_item(1'b0, 1'b0, 4'hF, 32'h100, 32'd0, 32'h24010005, 1'b0, 4'd3);
    expect_stall("fetch_wait", 4, 6'b000111);
    expect_stall("fetch_done", 1, 6'b000000);
    tick(); if_req = 1'b0;
    expect_stall("fetch_idle", 2, 6'b000000);

    // Contention: MEM load wins, IF follows after one idle cycle.
    tick(); if_req = 1'b1; if_addr = 32'h104; mem_req = 1'b1; mem_we = 1'b0;
    mem_sel = 4'hF; mem_addr = 32'h200;
    push_item(1'b1, 1'b0, 4'hF, 32'h200, 32'd0, 32'h8C220010, 1'b0, 4'd3);
    push_item(1'b0, 1'b0, 4'hF, 32'h104, 32'd0, 32'hA5A5A4A1, 1'b0, 4'd3);
    expect_stall("cont_mem_wait", 4, 6'b011111);
    expect_stall("cont_mem_done", 1, 6'b000111);
    tick(); mem_req = 1'b0;
    expect_stall("cont_if_wait", 3, 6'b000111);
    expect_stall("cont_if_done", 1, 6'b000000);
    tick(); if_req = 1'b0;
    expect_stall("cont_idle", 2, 6'b000000);

    // Buffered hold: fetch completes under an EX stall; no second bus cycle.
    tick(); if_req = 1'b1; if_addr = 32'h108; stallreq_from_ex = 1'b1;
    push_item(1'b0, 1'b0, 4'hF, 32'h108, 32'd0, 32'hA5A5A4AD, 1'b0, 4'd3);
    expect_stall("hold_ex", 7, 6'b001111);
    chk("hold_if_rdata", if_rdata, 32'hA5A5A4AD);
    tick(); stallreq_from_ex = 1'b0;
    expect_stall("hold_release", 1, 6'b000000);
    tick(); if_req = 1'b0;
    expect_stall("hold_idle", 2, 6'b000000);

    // Store: mem_rdata keeps the earlier load data.
    tick(); mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h300;
    mem_wdata = 32'hDEADBEEF;
    push_item(1'b1, 1'b1, 4'b0011, 32'h300, 32'hDEADBEEF, 32'h8C220010, 1'b0, 4'd3);
    expect_stall("store_wait", 4, 6'b011111);
    expect_stall("store_done", 1, 6'b000000);
    tick(); mem_req = 1'b0; mem_we = 1'b0;
    expect_stall("store_idle", 2, 6'b000000);

    // Timeout: no ack, four bus cycles, one bus_err pulse, zero data.
    resp_en = 1'b0;
    tick(); mem_req = 1'b1; mem_sel = 4'hF; mem_addr = 32'h400; mem_wdata = 32'd0;
    push_item(1'b1, 1'b0, 4'hF, 32'h400, 32'd0, 32'd0, 1'b1, 4'd4);
    expect_stall("tmo_wait", 5, 6'b011111);
    expect_stall("tmo_done", 1, 6'b000000);
    tick(); mem_req = 1'b0;
    @(negedge clk);
    chk("tmo_err_single", {31'd0, bus_err}, 32'd0);
    chk("tmo_mem_rdata", mem_rdata, 32'd0);
    expect_stall("tmo_idle", 1, 6'b000000);

    // Reset during MEM_BUSY.
    tick(); mem_req = 1'b1; mem_addr = 32'h500;
    push_item(1'b1, 1'b0, 4'hF, 32'h500, 32'd0, 32'd0, 1'b0, 4'd1);
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_rst", {31'd0, bus_req}, 32'd1);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("stall_in_rst", {26'd0, stall}, 32'd0);
    @(negedge clk);
    chk("rst_edge_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_edge_stall", {26'd0, stall}, 32'd0);
    chk("rst_edge_if_rdata", if_rdata, 32'd0);
    tick(); mem_req = 1'b0;
    tick(); rst = 1'b0; resp_en = 1'b1;
    expect_stall("post_rst_idle", 1, 6'b000000);

    tick(); if_req = 1'b1; if_addr = 32'h600;
    push_item(1'b0, 1'b0, 4'hF, 32'h600, 32'd0, 32'hA5A5A3A5, 1'b0, 4'd3);
    expect_stall("post_rst_wait", 4, 6'b000111);
    expect_stall("post_rst_done", 1, 6'b000000);
    tick(); if_req = 1'b0;
    expect_stall("final_idle", 3, 6'b000000);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
